// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller and related stage logic.
package pipe_pkg;

  // Sequencer states; the encoding is fixed so other stages can decode it
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Register $zero never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use dependency compare between the load in ID/EX and the operands in IF/ID.
// Kept standalone so the forwarding unit can reuse the same compare.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  output logic       load_use
);

  // A load into a non-zero register that the next instruction reads
  assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer beside the ID stage: load-use stalls, branch squash,
// and freezing the pipe while a fixed-latency data memory completes.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             br_taken,
  input  logic             exmem_memreq,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt
);

  // The access occupies EX/MEM for MEM_LAT cycles: the entering RUN cycle and
  // MEM_LAT-2 MEMWAIT cycles are frozen, then RELEASE lets it advance.
  localparam bit MEM_STALLS = (MEM_LAT > 1);
  localparam bit USE_WAIT   = (MEM_LAT > 2);
  localparam int CW         = USE_WAIT ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(USE_WAIT ? (MEM_LAT - 2) : 0);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .load_use     (load_use)
  );

  // Next state, wait counter and Mealy outputs; cnt_q holds the MEMWAIT cycles still to go
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;

    case (state_q)
      RUN, RELEASE: begin
        if (state_q == RUN && MEM_STALLS && exmem_memreq) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          if (USE_WAIT) begin
            state_d = MEMWAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (br_taken) begin
            ifid_flush = 1'b1;
          end
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter and performance counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
